// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM/IO port between icache line fills and dcache loads/stores.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise the dcache wins every tie.
module mem_arbiter #(
    parameter int ILINE_BYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     icache_req,
    input  logic [17:0]              icache_addr,
    output logic                     icache_feedback_en,
    output logic [ILINE_BYTES*8-1:0] icache_data,
    input  logic                     dcache_rw_en,
    input  logic                     dcache_write_mode,
    input  logic [1:0]               dcache_width,
    input  logic                     dcache_sign_ext,
    input  logic [17:0]              dcache_addr,
    input  logic [31:0]              dcache_value,
    output logic                     dcache_idle,
    output logic                     dcache_rw_feedback_en,
    output logic [31:0]              dcache_load_val,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [17:0]              mem_a,
    output logic                     mem_wr,
    input  logic                     io_buffer_full
);
    localparam int AW = 18;
    localparam int CW = $clog2(ILINE_BYTES + 2);

    typedef enum logic [1:0] {IDLE, ILOAD, DLOAD, DSTORE} state_t;

    typedef struct packed {
        logic          write;
        logic [1:0]    width;
        logic          sign_ext;
        logic [AW-1:0] addr;
        logic [31:0]   value;
    } dreq_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, len, cap_idx;
    logic          dpend;
    dreq_t         d_req, live_req, cur_req;
    logic [AW-1:0] i_addr, base, byte_addr;
    logic          d_accept, d_cand, i_cand, grant_d, grant_i, io_stall;
    logic [7:0]    store_byte;
    logic [31:0]   dbuf, load_raw, load_ext;
`ifdef MEM_ARB_RR_EN
    logic          last_grant_i;
`endif

    function automatic logic [CW-1:0] dcache_len(input logic [1:0] width);
        case (width)
            2'b00:   return CW'(1);
            2'b01:   return CW'(2);
            default: return CW'(4);
        endcase
    endfunction

    assign live_req = {dcache_write_mode, dcache_width, dcache_sign_ext, dcache_addr, dcache_value};

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        dcache_idle = !dpend && (state != DLOAD) && (state != DSTORE);
        d_accept    = dcache_rw_en && dcache_idle;
        cur_req     = d_accept ? live_req : d_req;
        d_cand      = dpend || d_accept;
        i_cand      = icache_req && !flush;
        grant_d     = 1'b0;
        grant_i     = 1'b0;
        next_state  = state;
        base        = d_req.addr;
        len         = dcache_len(d_req.width);
        case (state)
            IDLE: begin
                if (d_cand && i_cand) begin
`ifdef MEM_ARB_RR_EN
                    grant_d = last_grant_i;
`else
                    grant_d = 1'b1;
`endif
                    grant_i = !grant_d;
                end else begin
                    grant_d = d_cand;
                    grant_i = i_cand;
                end
                if (grant_i) begin
                    next_state = ILOAD;
                    base       = icache_addr;
                end else if (grant_d) begin
                    next_state = cur_req.write ? DSTORE : DLOAD;
                    base       = cur_req.addr;
                end
            end
            ILOAD: begin
                base = i_addr;
                len  = CW'(ILINE_BYTES);
                if (flush || cnt == len + CW'(1)) next_state = IDLE;
            end
            DLOAD:  if (cnt == len + CW'(1)) next_state = IDLE;
            DSTORE: if (cnt == len) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        byte_addr  = base + AW'(cnt);
        cap_idx    = cnt - CW'(2);
        store_byte = (state == IDLE) ? cur_req.value[7:0] : d_req.value[8*cnt[1:0] +: 8];
        io_stall   = (byte_addr[17:16] == 2'b11) && io_buffer_full;
    end

    // The byte arriving this edge is the top byte of the access, so the sign comes from mem_din.
    always_comb begin
        load_raw = dbuf;
        load_raw[8*cap_idx[1:0] +: 8] = mem_din;
        case (d_req.width)
            2'b00:   load_ext = {{24{d_req.sign_ext & load_raw[7]}}, load_raw[7:0]};
            2'b01:   load_ext = {{16{d_req.sign_ext & load_raw[15]}}, load_raw[15:0]};
            default: load_ext = load_raw;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt                   <= '0;
            dpend                 <= 1'b0;
            d_req                 <= '0;
            i_addr                <= '0;
            dbuf                  <= '0;
            mem_a                 <= '0;
            mem_dout              <= '0;
            mem_wr                <= 1'b0;
            icache_feedback_en    <= 1'b0;
            dcache_rw_feedback_en <= 1'b0;
            icache_data           <= '0;
            dcache_load_val       <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_i          <= 1'b1;
`endif
        end else begin
            icache_feedback_en    <= 1'b0;
            dcache_rw_feedback_en <= 1'b0;
            mem_wr                <= 1'b0;
            if (d_accept) d_req <= live_req;
            if (grant_d)       dpend <= 1'b0;
            else if (d_accept) dpend <= 1'b1;

            case (state)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        mem_a <= byte_addr;
`ifdef MEM_ARB_RR_EN
                        last_grant_i <= grant_i;
`endif
                    end
                    if (grant_i) begin
                        i_addr <= icache_addr;
                        cnt    <= CW'(1);
                    end else if (grant_d) begin
                        dbuf <= '0;
                        if (cur_req.write) begin
                            mem_dout <= store_byte;
                            mem_wr   <= !io_stall;
                            cnt      <= io_stall ? '0 : CW'(1);
                        end else begin
                            cnt <= CW'(1);
                        end
                    end
                end
                ILOAD: begin
                    if (flush) begin
                        cnt <= '0;
                    end else begin
                        if (cnt < len) mem_a <= byte_addr;
                        if (cnt >= CW'(2)) icache_data[8*cap_idx +: 8] <= mem_din;
                        if (cnt == len + CW'(1)) begin
                            icache_feedback_en <= 1'b1;
                            cnt                <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DLOAD: begin
                    if (cnt < len) mem_a <= byte_addr;
                    if (cnt >= CW'(2)) dbuf <= load_raw;
                    if (cnt == len + CW'(1)) begin
                        dcache_load_val       <= load_ext;
                        dcache_rw_feedback_en <= 1'b1;
                        cnt                   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DSTORE: begin
                    if (cnt == len) begin
                        dcache_rw_feedback_en <= 1'b1;
                        cnt                   <= '0;
                    end else begin
                        // A full IO buffer holds the byte index so the same byte is retried.
                        mem_a    <= byte_addr;
                        mem_dout <= store_byte;
                        mem_wr   <= !io_stall;
                        if (!io_stall) cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide one-cycle-latency RAM model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst, flush, icache_req;
    logic [17:0] icache_addr;
    logic        icache_feedback_en;
    logic [31:0] icache_data;
    logic        dcache_rw_en, dcache_write_mode, dcache_sign_ext;
    logic [1:0]  dcache_width;
    logic [17:0] dcache_addr;
    logic [31:0] dcache_value;
    logic        dcache_idle, dcache_rw_feedback_en;
    logic [31:0] dcache_load_val;
    logic [7:0]  mem_din, mem_dout;
    logic [17:0] mem_a;
    logic        mem_wr, io_buffer_full;

    int n_cmp = 0;
    int n_bad = 0;
    int ifb_seen = 0;
    int dfb_seen = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ILINE_BYTES(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_feedback_en(icache_feedback_en), .icache_data(icache_data),
        .dcache_rw_en(dcache_rw_en), .dcache_write_mode(dcache_write_mode),
        .dcache_width(dcache_width), .dcache_sign_ext(dcache_sign_ext),
        .dcache_addr(dcache_addr), .dcache_value(dcache_value),
        .dcache_idle(dcache_idle), .dcache_rw_feedback_en(dcache_rw_feedback_en),
        .dcache_load_val(dcache_load_val),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    logic [7:0]  ram [0:262143];
    logic        pre_en = 1'b0;
    logic [17:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clk) begin
        if (pre_en)      ram[pre_addr] <= pre_data;
        else if (mem_wr) ram[mem_a]    <= mem_dout;
        mem_din <= ram[mem_a];
    end

    always @(negedge clk) begin
        if (icache_feedback_en)    ifb_seen += 1;
        if (dcache_rw_feedback_en) dfb_seen += 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp += 1;
        if (got !== exp) begin
            n_bad += 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic dreq(input logic wr, input logic [1:0] w, input logic sx,
                        input logic [17:0] a, input logic [31:0] v);
        dcache_write_mode = wr;
        dcache_width      = w;
        dcache_sign_ext   = sx;
        dcache_addr       = a;
        dcache_value      = v;
        dcache_rw_en      = 1'b1;
        tick();
        dcache_rw_en      = 1'b0;
    endtask

    task automatic wait_dfb(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (dcache_rw_feedback_en) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_ifb(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (icache_feedback_en) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n;
        int seen;
        rst = 1'b1; flush = 1'b0; icache_req = 1'b0; icache_addr = '0;
        dcache_rw_en = 1'b0; dcache_write_mode = 1'b0; dcache_width = '0;
        dcache_sign_ext = 1'b0; dcache_addr = '0; dcache_value = '0;
        io_buffer_full = 1'b0;
        tick();
        poke(18'h00100, 8'h11); poke(18'h00101, 8'h22);
        poke(18'h00102, 8'h33); poke(18'h00103, 8'h44);
        poke(18'h00004, 8'h80);
        poke(18'h00020, 8'h34); poke(18'h00021, 8'hC2);
        poke(18'h3FFFF, 8'hAA); poke(18'h00000, 8'hBB);
        poke(18'h00001, 8'hCC); poke(18'h00002, 8'hDD);
        poke(18'h00200, 8'hA0); poke(18'h00201, 8'hA1);
        poke(18'h00202, 8'hA2); poke(18'h00203, 8'hA3);

        check("rst_idle", dcache_idle, 1);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_dout", mem_dout, 0);
        check("rst_dfb", dcache_rw_feedback_en, 0);
        check("rst_ifb", icache_feedback_en, 0);
        check("rst_load_val", dcache_load_val, 0);
        check("rst_icache_data", icache_data, 0);
        rst = 1'b0;
        tick();

        // Word load: byte addresses on consecutive edges, feedback after E5.
        dreq(1'b0, 2'b10, 1'b0, 18'h00100, 0);
        check("wl_e0_addr", mem_a, 32'h100);
        check("wl_e0_busy", dcache_idle, 0);
        tick();
        check("wl_e1_addr", mem_a, 32'h101);
        tick(); tick();
        check("wl_e3_addr", mem_a, 32'h103);
        check("wl_e3_wr", mem_wr, 0);
        wait_dfb(10, n);
        check("wl_latency_after_e3", n, 2);
        check("wl_val", dcache_load_val, 32'h44332211);
        check("wl_fb_idle", dcache_idle, 1);

        // Back-to-back byte/half loads with sign handling, and an address wrap.
        dreq(1'b0, 2'b00, 1'b1, 18'h00004, 0);
        wait_dfb(10, n);
        check("bl_sx_latency", n, 2);
        check("bl_sx_val", dcache_load_val, 32'hFFFFFF80);
        dreq(1'b0, 2'b00, 1'b0, 18'h00004, 0);
        wait_dfb(10, n);
        check("bl_zx_val", dcache_load_val, 32'h00000080);
        dreq(1'b0, 2'b01, 1'b1, 18'h00020, 0);
        wait_dfb(10, n);
        check("hl_sx_latency", n, 3);
        check("hl_sx_val", dcache_load_val, 32'hFFFFC234);
        dreq(1'b0, 2'b10, 1'b0, 18'h3FFFF, 0);
        wait_dfb(10, n);
        check("wrap_val", dcache_load_val, 32'hDDCCBBAA);

        // Half store, then read it back sign-extended.
        dreq(1'b1, 2'b01, 1'b0, 18'h00010, 32'h1234BEEF);
        check("hs_e0_wr", mem_wr, 1);
        check("hs_e0_addr", mem_a, 32'h10);
        check("hs_e0_data", mem_dout, 32'hEF);
        tick();
        check("hs_e1_wr", mem_wr, 1);
        check("hs_e1_addr", mem_a, 32'h11);
        check("hs_e1_data", mem_dout, 32'hBE);
        check("hs_e1_fb", dcache_rw_feedback_en, 0);
        tick();
        check("hs_e2_fb", dcache_rw_feedback_en, 1);
        check("hs_e2_wr", mem_wr, 0);
        dreq(1'b0, 2'b01, 1'b1, 18'h00010, 0);
        wait_dfb(10, n);
        check("hs_readback", dcache_load_val, 32'hFFFFBEEF);

        // IO store stalled for three edges by a full buffer.
        io_buffer_full = 1'b1;
        dreq(1'b1, 2'b00, 1'b0, 18'h30000, 32'h0000005A);
        check("io_e0_wr", mem_wr, 0);
        tick();
        check("io_e1_wr", mem_wr, 0);
        tick();
        check("io_e2_wr", mem_wr, 0);
        io_buffer_full = 1'b0;
        tick();
        check("io_e3_wr", mem_wr, 1);
        check("io_e3_addr", mem_a, 32'h30000);
        check("io_e3_data", mem_dout, 32'h5A);
        check("io_e3_fb", dcache_rw_feedback_en, 0);
        tick();
        check("io_e4_fb", dcache_rw_feedback_en, 1);

        // A full buffer does not stall stores outside the IO region.
        io_buffer_full = 1'b1;
        dreq(1'b1, 2'b00, 1'b0, 18'h20000, 32'h00000066);
        check("nio_e0_wr", mem_wr, 1);
        tick();
        check("nio_e1_fb", dcache_rw_feedback_en, 1);
        io_buffer_full = 1'b0;

        // Reset in the middle of a word load: no feedback afterwards.
        dreq(1'b0, 2'b10, 1'b0, 18'h00100, 0);
        tick(); tick();
        seen = dfb_seen;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_idle", dcache_idle, 1);
        check("mrst_mem_wr", mem_wr, 0);
        repeat (6) tick();
        check("mrst_no_fb", dfb_seen, seen);

        // Two simultaneous icache/dcache requests in a row, starting from reset.
        icache_addr = 18'h00200;
        icache_req  = 1'b1;
        dreq(1'b0, 2'b10, 1'b0, 18'h00100, 0);
        check("arb1_winner", mem_a, 32'h100);
        wait_dfb(10, n);
        check("arb1_val", dcache_load_val, 32'h44332211);
        dreq(1'b0, 2'b00, 1'b0, 18'h00004, 0);
`ifdef MEM_ARB_RR_EN
        check("arb2_winner", mem_a, 32'h200);
        check("arb2_dpend", dcache_idle, 0);
        wait_ifb(12, n);
        check("arb2_ifill_latency", n, 5);
        check("arb2_ifill_data", icache_data, 32'hA3A2A1A0);
        icache_req = 1'b0;
        wait_dfb(12, n);
        check("arb2_dload_latency", n, 3);
        check("arb2_dload_val", dcache_load_val, 32'h80);
`else
        check("arb2_winner", mem_a, 32'h4);
        wait_dfb(12, n);
        check("arb2_dload_latency", n, 2);
        check("arb2_dload_val", dcache_load_val, 32'h80);
        wait_ifb(12, n);
        check("arb2_ifill_latency", n, 6);
        check("arb2_ifill_data", icache_data, 32'hA3A2A1A0);
        icache_req = 1'b0;
`endif
        tick();

        // Flush mid-fill with a dcache load accepted during the fill.
        seen = ifb_seen;
        icache_req = 1'b1;
        tick();
        check("fl_e0_addr", mem_a, 32'h200);
        check("fl_idle_in_iload", dcache_idle, 1);
        dreq(1'b0, 2'b00, 1'b1, 18'h00004, 0);
        check("fl_dpend", dcache_idle, 0);
        tick();
        flush = 1'b1;
        icache_req = 1'b0;
        tick();
        flush = 1'b0;
        wait_dfb(12, n);
        check("fl_dload_latency", n, 3);
        check("fl_dload_val", dcache_load_val, 32'hFFFFFF80);
        repeat (6) tick();
        check("fl_no_ifb", ifb_seen, seen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Sits between the instruction cache, the data cache and the single byte-wide RAM/IO port.
- Arbitrates between icache line fills and dcache load/store requests.
- Sequences each multi-byte access as consecutive byte transfers.
- Assembles little-endian load data with sign extension, and stalls IO writes while the IO buffer is full.

## Interface
Parameters:
- ILINE_BYTES, 4, bytes per icache fill (power of two, 4..64)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; aborts an icache fill
- icache_req  in  1  level fill request, held until feedback or flush
- icache_addr  in  18  line base address, ILINE_BYTES-aligned
- icache_feedback_en  out  1  one-cycle pulse, fill data valid
- icache_data  out  ILINE_BYTES*8  fill data, byte i at bits [8i+7:8i]
- dcache_rw_en  in  1  one-cycle request pulse, legal only while dcache_idle=1
- dcache_write_mode  in  1  1=store, 0=load
- dcache_width  in  2  00 byte, 01 half, 10 word; 11 treated as word
- dcache_sign_ext  in  1  sign-extend load result
- dcache_addr  in  18  byte address
- dcache_value  in  32  store data, low bytes used
- dcache_idle  out  1  arbiter can accept a dcache request this cycle
- dcache_rw_feedback_en  out  1  one-cycle pulse, access complete
- dcache_load_val  out  32  load result, valid with feedback
- mem_din  in  8  RAM read byte, one-cycle latency
- mem_dout  out  8  RAM write byte
- mem_a  out  18  RAM byte address
- mem_wr  out  1  1=write
- io_buffer_full  in  1  IO write buffer full

## Operation
- State machine states: IDLE, ILOAD, DLOAD, DSTORE.
  - A byte counter cnt and a dcache pending register (dpend plus latched fields) support the sequencing.
- dcache_idle = !dpend && state∉{DLOAD, DSTORE}.
  - A dcache_rw_en seen with dcache_idle=1 latches into dpend.
  - A request accepted while in ILOAD waits until the fill ends.
- Grant, evaluated in IDLE on each edge:
  - Candidates are dpend (or dcache_rw_en this cycle) and icache_req && !flush.
  - Tie-break follows the Configuration section.
- Transfer length N:
  - Icache fill: ILINE_BYTES.
  - Dcache access: 1, 2 or 4 bytes per width.
- Bytes are addressed at addr+i, i=0..N-1; the 18-bit address wraps modulo 2^18.
- Loads:
  - Byte i is assembled into bits [8i+7:8i].
  - For dcache loads, bits above 8N are filled with zeros, or with copies of the top bit of the loaded data when sign_ext=1.
- Stores:
  - Byte i of dcache_value is driven on mem_dout with mem_wr=1.
  - If addr[17:16]==2'b11 and io_buffer_full=1 on the issuing edge, drive mem_wr=0, hold cnt, and retry on the next edge.
- Flush:
  - In ILOAD, flush returns the arbiter to IDLE on the next edge with no icache feedback.
  - Flush in DLOAD, DSTORE or with dpend set has no effect; dcache accesses always complete and always pulse feedback.
- Reset values: state IDLE, cnt 0, dpend 0, mem_a 0, mem_dout 0, mem_wr 0, both feedbacks 0, icache_data 0, dcache_load_val 0, last_grant=icache.

## Timing
- Grant edge E0 drives the byte 0 address; byte i's address appears after edge Ei.
- Read latency:
  - mem_din carries byte i after E(i+1), and it is captured at E(i+2).
  - Load feedback is high for exactly the cycle after E(N+1), with data valid in that cycle.
  - Word load: feedback after E5.
- Store: feedback pulses after E(N), plus one edge per IO stall cycle.
- The arbiter is back in IDLE during the feedback cycle.
  - dcache_idle=1 in that cycle, so a back-to-back dcache request is granted at the next edge.
- mem_wr=0 in every cycle that is not a store byte.
- Reset mid-transfer: the arbiter goes to IDLE immediately and no feedback is produced.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - When both requesters are ready, the requester not granted last wins.
  - last_grant updates on every grant; after reset the dcache wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority; the dcache always wins ties.

## Test plan
- Word load at 0x00100, RAM bytes 11,22,33,44 -> dcache_rw_feedback_en after E5, dcache_load_val=0x44332211.
- Byte load at 0x00004 with sign_ext=1, RAM byte 0x80 -> load_val=0xFFFFFF80; same with sign_ext=0 -> 0x00000080.
- Half store 0xBEEF to 0x00010 -> mem_wr=1 with (0x00010,EF), then (0x00011,BE); feedback after E2.
- icache_req and dcache_rw_en in the same cycle, twice in a row:
  - RR_EN defined: dcache, then icache.
  - RR_EN undefined: dcache both times, icache only after dcache_idle.
- Byte store to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 edges, then one write; feedback 3 cycles late.
- flush asserted at E2 of an ILINE_BYTES=4 fill -> IDLE after E3, no icache_feedback_en; a pending dcache load is then served normally.
